blk_mem_arbiter: RTL and testbench

Sequential arbiter for the single main-memory block port shared by the instruction-cache refill path and the data-cache refill/writeback path. It sits between the two cache controllers and the MIPS top-level block port (iBlkRead/dBlkRead/dBlkWrite side). It alternates grants fairly between the two requesters and runs each 256-bit transfer to completion. It bounds every transfer with a timeout so a lost memory response cannot hang the pipeline.

---
 rtl/blk_mem_arbiter.sv | 119 +++++++++++
 tb/tb_blk_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/blk_mem_arbiter.sv
// Round-robin arbiter sharing one 256-bit main-memory block port between the
// I-cache refill path and the D-cache refill/writeback path, with a transfer timeout.
module blk_mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    output logic         i_ack,
    output logic         i_err,
    output logic [255:0] i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic         d_ack,
    output logic         d_err,
    output logic [255:0] d_rdata,
    output logic [31:0]  mem_addr,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_rd_valid,
    input  logic         mem_wr_valid,
    output logic         busy
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

    state_t        state, state_nx;
    logic          last_d;     // 1 when the D side held the most recent grant
    logic [TW-1:0] timer;
    logic          resp_d;     // side being answered in RESP
    logic          resp_err;
    logic          grant_i, grant_d, done, tmo;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    grant_i  = 1'b1;
                    state_nx = I_RD;
                end else if (d_req) begin
                    grant_d  = 1'b1;
                    state_nx = d_we ? D_WR : D_RD;
                end
            end
            I_RD, D_RD, D_WR: begin
                // only the valid matching the transfer direction completes it
                if ((state == D_WR) ? mem_wr_valid : mem_rd_valid) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            timer     <= '0;
            last_d    <= 1'b0;
            resp_d    <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            if (grant_i) begin
                mem_addr <= i_addr;
                last_d   <= 1'b0;
                resp_d   <= 1'b0;
                timer    <= '0;
            end
            if (grant_d) begin
                mem_addr <= d_addr;
                if (d_we) mem_wdata <= d_wdata;
                last_d   <= 1'b1;
                resp_d   <= 1'b1;
                timer    <= '0;
            end
            if (done) begin
                resp_err <= 1'b0;
                if (state == I_RD) i_rdata <= mem_rdata;
                if (state == D_RD) d_rdata <= mem_rdata;
            end else if (tmo) begin
                resp_err <= 1'b1;
            end else if (state == I_RD || state == D_RD || state == D_WR) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign mem_rd = (state == I_RD) || (state == D_RD);
    assign mem_wr = (state == D_WR);
    assign busy   = (state != IDLE);
    assign i_ack  = (state == RESP) && !resp_d && !resp_err;
    assign i_err  = (state == RESP) && !resp_d &&  resp_err;
    assign d_ack  = (state == RESP) &&  resp_d && !resp_err;
    assign d_err  = (state == RESP) &&  resp_d &&  resp_err;
endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Directed table-driven bench for blk_mem_arbiter (TIMEOUT=8): per-cycle control
// vectors plus hand sequences for data capture and mid-transfer reset.
module tb_blk_mem_arbiter;
    localparam logic [31:0] IA = 32'h0040_0020;
    localparam logic [31:0] DA = 32'h1000_8000;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         i_req, i_ack, i_err;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         d_req, d_we, d_ack, d_err;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata, d_rdata;
    logic [31:0]  mem_addr;
    logic         mem_rd, mem_wr, mem_rd_valid, mem_wr_valid, busy;
    logic [255:0] mem_wdata, mem_rdata;

    blk_mem_arbiter #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // in  = {i_req, d_req, d_we, mem_rd_valid, mem_wr_valid}
    // out = {mem_rd, mem_wr, i_ack, i_err, d_ack, d_err, busy}
    // ea  = expected mem_addr: 0 -> zero, 1 -> IA, 2 -> DA
    typedef struct {
        logic [4:0] in;
        logic [6:0] out;
        logic [1:0] ea;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    int   seg   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] in, input logic [6:0] out, input logic [1:0] ea,
                       input int n = 1);
        vec_t v;
        v.in = in; v.out = out; v.ea = ea;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vecs;
        logic [31:0] ea;
        for (int k = 0; k < vq.size(); k++) begin
            {i_req, d_req, d_we, mem_rd_valid, mem_wr_valid} = vq[k].in;
            ea = (vq[k].ea == 2'd1) ? IA : (vq[k].ea == 2'd2) ? DA : 32'h0;
            chk($sformatf("s%0d_c%0d_ctl", seg, k),
                256'({mem_rd, mem_wr, i_ack, i_err, d_ack, d_err, busy}), 256'(vq[k].out));
            chk($sformatf("s%0d_c%0d_addr", seg, k), 256'(mem_addr), 256'(ea));
            tick();
        end
        vq.delete();
        seg++;
    endtask

    initial begin
        RESET = 1'b1;
        {i_req, d_req, d_we, mem_rd_valid, mem_wr_valid} = '0;
        i_addr = IA; d_addr = DA;
        d_wdata = {8{32'h1234_5678}};
        mem_rdata = {8{32'hA5A5_A5A5}};
        tick(); tick();
        chk("rst_ctl", 256'({mem_rd, mem_wr, i_ack, i_err, d_ack, d_err, busy}), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_irdata", i_rdata, 256'(0));
        chk("rst_drdata", d_rdata, 256'(0));
        RESET = 1'b0;

        // I read alone; stray mem_wr_valid mid-transfer ignored; valid at cycle 3
        add(5'b10000, 7'b0000000, 2'd0);
        add(5'b10000, 7'b1000001, 2'd1);
        add(5'b10001, 7'b1000001, 2'd1);
        add(5'b10010, 7'b1000001, 2'd1);
        add(5'b10000, 7'b0010001, 2'd1);
        add(5'b00000, 7'b0000000, 2'd1);
        run_vecs();
        chk("A_irdata", i_rdata, {8{32'hA5A5_A5A5}});
        chk("A_drdata", d_rdata, 256'(0));

        // simultaneous requests after reset-state last_grant=I: D, I, D, I
        mem_rdata = {8{32'hC3C3_0001}};
        add(5'b11000, 7'b0000000, 2'd1);
        add(5'b11010, 7'b1000001, 2'd2);
        add(5'b11000, 7'b0000101, 2'd2);
        add(5'b10000, 7'b0000000, 2'd2);
        add(5'b11010, 7'b1000001, 2'd1);
        add(5'b11000, 7'b0010001, 2'd1);
        add(5'b01000, 7'b0000000, 2'd1);
        add(5'b01010, 7'b1000001, 2'd2);
        add(5'b01000, 7'b0000101, 2'd2);
        add(5'b10000, 7'b0000000, 2'd2);
        add(5'b10010, 7'b1000001, 2'd1);
        add(5'b10000, 7'b0010001, 2'd1);
        add(5'b00000, 7'b0000000, 2'd1);
        run_vecs();
        chk("B_irdata", i_rdata, {8{32'hC3C3_0001}});
        chk("B_drdata", d_rdata, {8{32'hC3C3_0001}});

        // D write, mem_wr_valid on its 5th transfer cycle
        mem_rdata = {8{32'h0F0F_0F0F}};
        add(5'b01100, 7'b0000000, 2'd1);
        add(5'b01100, 7'b0100001, 2'd2, 4);
        add(5'b01101, 7'b0100001, 2'd2);
        add(5'b01100, 7'b0000101, 2'd2);
        add(5'b00000, 7'b0000000, 2'd2);
        run_vecs();
        chk("C_wdata", mem_wdata, {8{32'h1234_5678}});
        chk("C_drdata_kept", d_rdata, {8{32'hC3C3_0001}});

        // tie with last_grant=D goes to I, then D read
        add(5'b11000, 7'b0000000, 2'd2);
        add(5'b11010, 7'b1000001, 2'd1);
        add(5'b11000, 7'b0010001, 2'd1);
        add(5'b01000, 7'b0000000, 2'd1);
        add(5'b01010, 7'b1000001, 2'd2);
        add(5'b01000, 7'b0000101, 2'd2);
        add(5'b00000, 7'b0000000, 2'd2);
        run_vecs();
        chk("C2_irdata", i_rdata, {8{32'h0F0F_0F0F}});

        // I timeout: mem_rd cycles 1..8, i_err at 9, then D served normally
        mem_rdata = {8{32'hDEAD_BEEF}};
        add(5'b10000, 7'b0000000, 2'd2);
        add(5'b10000, 7'b1000001, 2'd1, 8);
        add(5'b10000, 7'b0001001, 2'd1);
        add(5'b01000, 7'b0000000, 2'd1);
        add(5'b01010, 7'b1000001, 2'd2);
        add(5'b01000, 7'b0000101, 2'd2);
        add(5'b00000, 7'b0000000, 2'd2);
        run_vecs();
        chk("D_irdata_kept", i_rdata, {8{32'h0F0F_0F0F}});
        chk("D_drdata", d_rdata, {8{32'hDEAD_BEEF}});

        // valid on the timeout cycle is a success; valids in IDLE ignored
        mem_rdata = {8{32'h7777_1111}};
        add(5'b10000, 7'b0000000, 2'd2);
        add(5'b10000, 7'b1000001, 2'd1, 7);
        add(5'b10010, 7'b1000001, 2'd1);
        add(5'b10000, 7'b0010001, 2'd1);
        add(5'b00011, 7'b0000000, 2'd1);
        add(5'b00000, 7'b0000000, 2'd1, 2);
        run_vecs();
        chk("E_irdata", i_rdata, {8{32'h7777_1111}});

        // reset during cycle 2 of a D read
        d_req = 1'b1; d_we = 1'b0;
        tick();
        chk("R_rd_c1", 256'(mem_rd), 256'(1));
        tick();
        RESET = 1'b1;
        tick();
        chk("R_ctl", 256'({mem_rd, mem_wr, i_ack, i_err, d_ack, d_err, busy}), 256'(0));
        chk("R_addr", 256'(mem_addr), 256'(0));
        chk("R_wdata", mem_wdata, 256'(0));
        chk("R_irdata", i_rdata, 256'(0));
        chk("R_drdata", d_rdata, 256'(0));
        RESET = 1'b0; d_req = 1'b0;
        tick();
        chk("R_after", 256'({mem_rd, d_ack, d_err, busy}), 256'(0));
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        chk("R_idle_valid", 256'({d_ack, d_err, i_ack, i_err, busy}), 256'(0));
        tick();
        chk("R_idle_valid2", 256'({d_ack, d_err, i_ack, i_err, busy}), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
